// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BR,
    RD_J,
    RD_JR
  } redir_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  fq_entry_t                wdata_i,
  output fq_entry_t                rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fq_entry_t      mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC owner, ROM driver and prefetch/bypass front end feeding IF/ID.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned IMEM_AW     = 8,
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Z,
  input  logic               J,
  input  logic               JR,
  input  logic               PC_IFWrite,
  input  logic [31:0]        BranchAddr,
  input  logic [31:0]        JumpAddr,
  input  logic [31:0]        JrAddr,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Instruction_if,
  output logic [31:0]        PC,
  output logic [31:0]        NextPC_if,
  output logic               Valid_if
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tag_q, tag_d;
  logic        infl_q, infl_d;

  redir_e      rsel;
  logic        redirect;
  logic [31:0] target;
  logic [CW:0] count, occ;
  fq_entry_t   head, resp;
  logic        full, have_q;
  logic        push, pop, fifo_pop, issue;

  assign redirect = Z | J | JR;

  always_comb begin
    rsel = RD_NONE;
    priority case (1'b1)
      JR:      rsel = RD_JR;
      J:       rsel = RD_J;
      Z:       rsel = RD_BR;
      default: rsel = RD_NONE;
    endcase
  end

  always_comb begin
    target = fpc_q;
    unique case (rsel)
      RD_JR:   target = JrAddr;
      RD_J:    target = JumpAddr;
      RD_BR:   target = BranchAddr;
      default: target = fpc_q;
    endcase
  end

  assign resp     = '{pc: tag_q, instr: imem_rdata};
  assign have_q   = (count != '0);
  assign Valid_if = have_q | infl_q;

  always_comb begin
    Instruction_if = NOP_INSTR;
    PC             = epc_q;
    if (have_q) begin
      Instruction_if = head.instr;
      PC             = head.pc;
    end else if (infl_q) begin
      Instruction_if = resp.instr;
      PC             = resp.pc;
    end
  end

  assign NextPC_if = PC + 32'd4;

  assign pop      = PC_IFWrite & Valid_if & ~redirect;
  assign fifo_pop = pop & have_q;
  // A bypassed response that is consumed immediately never enters the queue.
  assign push     = infl_q & ~redirect & ~(pop & ~have_q);

  assign occ   = count + (CW+1)'(infl_q) - (CW+1)'(pop);
  assign issue = ~reset & ~redirect & (occ < (CW+1)'(QUEUE_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = fpc_q[IMEM_AW+1:2];

  always_comb begin
    fpc_d  = fpc_q;
    epc_d  = epc_q;
    tag_d  = tag_q;
    infl_d = 1'b0;
    if (redirect) begin
      fpc_d = target;
      epc_d = target;
    end else begin
      if (issue) begin
        fpc_d  = fpc_q + 32'd4;
        tag_d  = fpc_q;
        infl_d = 1'b1;
      end
      if (pop) epc_d = epc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q  <= RESET_PC;
      epc_q  <= RESET_PC;
      tag_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      fpc_q  <= fpc_d;
      epc_q  <= epc_d;
      tag_q  <= tag_d;
      infl_q <= infl_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .clear_i (redirect),
    .wdata_i (resp),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full)
  );

  a_count_bound: assert property (
    @(posedge clk) disable iff (reset) count <= (CW+1)'(QUEUE_DEPTH));
  a_no_push_full: assert property (
    @(posedge clk) disable iff (reset) !(push && full));
  a_no_issue_redir: assert property (
    @(posedge clk) disable iff (reset) !(imem_en && redirect));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue with a 1-cycle ROM model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        Z, J, JR, PC_IFWrite;
  logic [31:0] BranchAddr, JumpAddr, JrAddr;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_if, PC, NextPC_if;
  logic        Valid_if;

  int          vec  = 0;
  int          errs = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .Z              (Z),
    .J              (J),
    .JR             (JR),
    .PC_IFWrite     (PC_IFWrite),
    .BranchAddr     (BranchAddr),
    .JumpAddr       (JumpAddr),
    .JrAddr         (JrAddr),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .Instruction_if (Instruction_if),
    .PC             (PC),
    .NextPC_if      (NextPC_if),
    .Valid_if       (Valid_if)
  );

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + 32'(pc[9:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input int ev, input int een);
    logic [31:0] e;
    chk("valid", 32'(Valid_if), 32'(ev));
    if (een >= 0) chk("imem_en", 32'(imem_en), 32'(een));
    if (!Valid_if) chk("nop", Instruction_if, 32'h0);
    if (Valid_if && PC_IFWrite && !(Z || J || JR)) begin
      vec++;
      assert (sb.size() > 0) else begin
        errs++;
        $error("FAIL sb_empty: got delivery pc %h want none", PC);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", PC, e);
        chk("instr", Instruction_if, word_at(e));
        chk("npc", NextPC_if, e + 32'd4);
      end
    end
  endtask

  task automatic cyc(input int ev, input int een);
    at_neg();
    observe(ev, een);
    adv();
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_en"}, 32'(imem_en), 32'h0);
    chk({tag, "_valid"}, 32'(Valid_if), 32'h0);
    chk({tag, "_instr"}, Instruction_if, 32'h0);
    chk({tag, "_pc"}, PC, 32'h0);
    chk({tag, "_npc"}, NextPC_if, 32'h4);
  endtask

  task automatic expect_stream(input logic [31:0] base, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
  endtask

  initial begin
    reset = 1'b1;
    Z = 1'b0; J = 1'b0; JR = 1'b0;
    PC_IFWrite = 1'b1;
    BranchAddr = '0; JumpAddr = '0; JrAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    at_neg();
    rst_chk("rst");
    adv();

    // Release and stream 0, 4, then stall with PC 8 shown.
    reset = 1'b0;
    expect_stream(32'h0, 5);
    cyc(0, 1);
    chk("first_addr", 32'(imem_addr), 32'h1);
    cyc(1, 1);
    cyc(1, 1);
    PC_IFWrite = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("stall_pc", PC, 32'h8);
      chk("stall_instr", Instruction_if, 32'h1000_0002);
      observe(1, (i == 0) ? 1 : 0);
      adv();
    end
    PC_IFWrite = 1'b1;
    cyc(1, 1);
    cyc(1, 1);
    cyc(1, 1);

    // JR back to 0, then J to 0x40 while PC 8 is shown.
    JR = 1'b1; JrAddr = 32'h0;
    cyc(1, 0);
    JR = 1'b0;
    expect_stream(32'h0, 3);
    at_neg();
    chk("jr_pc", PC, 32'h0);
    observe(0, 1);
    adv();
    cyc(1, 1);
    cyc(1, 1);
    J = 1'b1; JumpAddr = 32'h40;
    at_neg();
    chk("j_cur_pc", PC, 32'h8);
    observe(1, 0);
    adv();
    J = 1'b0;
    expect_stream(32'h40, 2);
    at_neg();
    chk("j_pc", PC, 32'h40);
    chk("j_addr", 32'(imem_addr), 32'h10);
    observe(0, 1);
    adv();
    cyc(1, 1);
    cyc(1, 1);

    // Z and JR together: JR target wins.
    Z = 1'b1; JR = 1'b1; BranchAddr = 32'h20; JrAddr = 32'h80;
    cyc(1, 0);
    Z = 1'b0; JR = 1'b0;
    expect_stream(32'h80, 2);
    at_neg();
    chk("prio_pc", PC, 32'h80);
    observe(0, 1);
    adv();
    cyc(1, 1);
    cyc(1, 1);

    // Fill the queue under stall, then branch while still stalled.
    PC_IFWrite = 1'b0;
    cyc(1, 1);
    cyc(1, 0);
    at_neg();
    chk("full_pc", PC, 32'h88);
    observe(1, 0);
    adv();
    Z = 1'b1; BranchAddr = 32'h10;
    cyc(1, 0);
    Z = 1'b0;
    PC_IFWrite = 1'b1;
    expect_stream(32'h10, 4);
    at_neg();
    chk("flush_pc", PC, 32'h10);
    observe(0, 1);
    adv();
    cyc(1, 1);
    cyc(1, 1);

    // Asynchronous reset with a read in flight.
    reset = 1'b1;
    #1;
    rst_chk("async");
    adv();
    reset = 1'b0;
    expect_stream(32'h0, 3);
    cyc(0, 1);
    cyc(1, 1);
    cyc(1, 1);
    cyc(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
